// File: rtl/psum_requant_if.sv
// Handshake bundle between the adder tree, the requantizer and its consumer.
// Signal names keep the block-side direction suffixes of psum_requant.
interface psum_requant_if #(
    parameter int InWidth    = 20,
    parameter int OutWidth   = 8,
    parameter int ShiftWidth = 5
);
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic signed [InWidth-1:0]    in_data_i;
    logic        [ShiftWidth-1:0] shift_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic signed [OutWidth-1:0]   out_data_o;
    logic                         out_sat_o;

    modport master (
        output in_valid_i, in_data_i, shift_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_sat_o
    );

    modport slave (
        input  in_valid_i, in_data_i, shift_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_sat_o
    );
endinterface

// File: rtl/psum_requant.sv
// Accumulates NumAcc adder-tree sums, then applies a round-half-up arithmetic shift
// and signed saturation to OutWidth bits into a registered valid/ready output.
module psum_requant #(
    parameter int InWidth    = 20,
    parameter int NumAcc     = 4,
    parameter int OutWidth   = 8,
    parameter int ShiftWidth = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    psum_requant_if.slave    bus
);
    localparam int AccWidth = InWidth + $clog2(NumAcc);
    localparam int CntWidth = (NumAcc > 1) ? $clog2(NumAcc) : 1;
    localparam int CmpWidth = ((AccWidth + 1 > OutWidth) ? AccWidth + 1 : OutWidth) + 1;
    localparam int unsigned MaxShift = AccWidth - 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumAcc - 1);
    localparam logic signed [CmpWidth-1:0] OutMax = CmpWidth'((64'sd1 <<< (OutWidth - 1)) - 64'sd1);
    localparam logic signed [CmpWidth-1:0] OutMin = CmpWidth'(-(64'sd1 <<< (OutWidth - 1)));

    // Returns {sat, data}; the compare width leaves room for the rounding carry.
    function automatic logic [OutWidth:0] requant(input logic signed [AccWidth-1:0] total,
                                                  input logic [ShiftWidth-1:0] shift);
        int unsigned                 sh;
        logic signed [CmpWidth-1:0]  rnd;
        logic signed [CmpWidth-1:0]  wide;
        logic signed [CmpWidth-1:0]  r;
        sh   = (32'(shift) > MaxShift) ? MaxShift : 32'(shift);
        rnd  = (sh > 32'd0) ? ({{(CmpWidth-1){1'b0}}, 1'b1} <<< (sh - 32'd1)) : '0;
        wide = CmpWidth'(total) + rnd;
        r    = wide >>> sh;
        if (r > OutMax) begin
            return {1'b1, OutMax[OutWidth-1:0]};
        end else if (r < OutMin) begin
            return {1'b1, OutMin[OutWidth-1:0]};
        end else begin
            return {1'b0, r[OutWidth-1:0]};
        end
    endfunction

    logic [CntWidth-1:0]          cnt_q, cnt_d;
    logic signed [AccWidth-1:0]   acc_q, acc_d;
    logic [ShiftWidth-1:0]        shift_q, shift_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [OutWidth-1:0]   out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;

    logic                         last_beat_s;
    logic                         in_ready_s;
    logic                         accept_s;
    logic                         first_beat_s;
    logic signed [AccWidth-1:0]   in_ext_s;
    logic signed [AccWidth-1:0]   total_s;
    logic [ShiftWidth-1:0]        shift_eff_s;
    logic [OutWidth:0]            result_s;

    // Handshake decode, accumulation datapath and next-state selection.
    always_comb begin
        last_beat_s  = (cnt_q == LastCnt);
        first_beat_s = (cnt_q == '0);
        in_ready_s   = !(last_beat_s && out_valid_q && !bus.out_ready_i);
        accept_s     = bus.in_valid_i && in_ready_s;
        in_ext_s     = AccWidth'(bus.in_data_i);
        // With NumAcc == 1 every beat is both first and last, so shift_i is used directly.
        shift_eff_s  = first_beat_s ? bus.shift_i : shift_q;
        total_s      = first_beat_s ? in_ext_s : (acc_q + in_ext_s);
        result_s     = requant(total_s, shift_eff_s);

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (accept_s) begin
            cnt_d   = last_beat_s ? '0 : (cnt_q + CntWidth'(1'b1));
            acc_d   = total_s;
            shift_d = shift_eff_s;
        end else begin
            cnt_d   = cnt_q;
            acc_d   = acc_q;
            shift_d = shift_q;
        end

        if (accept_s && last_beat_s) begin
            out_valid_d = 1'b1;
            out_data_d  = result_s[OutWidth-1:0];
            out_sat_d   = result_s[OutWidth];
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_sat_o   = out_sat_q;
endmodule

// File: tb/tb_psum_requant.sv
// Self-checking bench for psum_requant: directed vector table, handshake corner
// sequences and randomized groups scored against a group-level arithmetic model.
module tb_psum_requant;
    localparam int IW = 20;
    localparam int NA = 4;
    localparam int OW = 8;
    localparam int SW = 5;
    localparam int AW = IW + 2;

    typedef struct {
        longint d;
        bit     s;
    } res_t;

    typedef struct {
        int d [4];
        int sh;
        int ed;
        bit es;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    res_t   expq[$];
    int     mcnt = 0;
    longint macc = 0;
    int     mshift = 0;
    vec_t   tbl [12];
    bit     rnd_done = 1'b0;

    always #5 clk = ~clk;

    psum_requant_if #(.InWidth(IW), .OutWidth(OW), .ShiftWidth(SW)) bus ();

    psum_requant #(.InWidth(IW), .NumAcc(NA), .OutWidth(OW), .ShiftWidth(SW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Group-level reference: round half up by adding 2^(s-1), floor shift, clip.
    function automatic res_t ref_requant(input longint total, input int sh);
        res_t   res;
        int     s;
        longint r;
        s = (sh > AW - 1) ? AW - 1 : sh;
        r = total + ((s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0);
        r = r >>> s;
        if (r > 127) begin
            res.d = 127; res.s = 1'b1;
        end else if (r < -128) begin
            res.d = -128; res.s = 1'b1;
        end else begin
            res.d = r; res.s = 1'b0;
        end
        return res;
    endfunction

    // Scoreboard: at each falling edge predict handshakes and check/consume results.
    always @(negedge clk) begin
        bit exp_ready;
        if (!rst) begin
            exp_ready = !(mcnt == NA - 1 && expq.size() > 0 && !bus.out_ready_i);
            chk("in_ready", bus.in_ready_o, exp_ready);
            chk("out_valid", bus.out_valid_o, expq.size() > 0);
            if (bus.out_valid_o && expq.size() > 0) begin
                chk("out_data", bus.out_data_o, expq[0].d);
                chk("out_sat", bus.out_sat_o, expq[0].s);
                if (bus.out_ready_i) void'(expq.pop_front());
            end
            if (bus.in_valid_i && exp_ready) begin
                if (mcnt == 0) begin
                    macc   = 0;
                    mshift = int'(bus.shift_i);
                end
                macc = macc + longint'(bus.in_data_i);
                if (mcnt == NA - 1) begin
                    expq.push_back(ref_requant(macc, mshift));
                    mcnt = 0;
                end else begin
                    mcnt = mcnt + 1;
                end
            end
        end
    end

    // Called and returning at 1 time unit after a rising edge.
    task automatic beat(input longint d, input int sh);
        int waited = 0;
        bit done = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = IW'(d);
        bus.shift_i    = SW'(sh);
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready_o) done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", waited);
                    done = 1'b1;
                end
            end
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic group4(input int a, input int b, input int c, input int d, input int sh);
        beat(a, sh); beat(b, sh); beat(c, sh); beat(d, sh);
    endtask

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                           input int sh, input int ed, input bit es);
        tbl[i].d[0] = a; tbl[i].d[1] = b; tbl[i].d[2] = c; tbl[i].d[3] = d;
        tbl[i].sh = sh; tbl[i].ed = ed; tbl[i].es = es;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        set_vec(0,  10, 20, 30, 40, 2, 25, 1'b0);
        set_vec(1,  -3, -3, -3, -1, 2, -2, 1'b0);
        set_vec(2,  100000, 100000, 100000, 100000, 0, 127, 1'b1);
        set_vec(3,  -100000, -100000, -100000, -100000, 0, -128, 1'b1);
        set_vec(4,  100, 27, 0, 0, 0, 127, 1'b0);
        set_vec(5,  100, 28, 0, 0, 0, 127, 1'b1);
        set_vec(6,  -100, -28, 0, 0, 0, -128, 1'b0);
        set_vec(7,  -100, -29, 0, 0, 0, -128, 1'b1);
        set_vec(8,  524287, 524287, 524287, 524287, 31, 1, 1'b0);
        set_vec(9,  -524288, -524288, -524288, -524288, 31, -1, 1'b0);
        set_vec(10, 3, 0, 0, 0, 1, 2, 1'b0);
        set_vec(11, -3, 0, 0, 0, 1, -1, 1'b0);

        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.shift_i     = '0;
        bus.out_ready_i = 1'b0;
        #2;
        chk("rst_in_ready", bus.in_ready_o, 1);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_out_data", bus.out_data_o, 0);
        chk("rst_out_sat", bus.out_sat_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors with the consumer always ready.
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            group4(tbl[i].d[0], tbl[i].d[1], tbl[i].d[2], tbl[i].d[3], tbl[i].sh);
            chk("tbl_valid", bus.out_valid_o, 1);
            chk("tbl_data", bus.out_data_o, tbl[i].ed);
            chk("tbl_sat", bus.out_sat_o, tbl[i].es);
            @(posedge clk);
            #1;
            chk("tbl_valid_drop", bus.out_valid_o, 0);
        end

        // Backpressure: beats 0-2 pass while a result waits, beat 3 stalls.
        group4(10, 20, 30, 40, 2);
        bus.out_ready_i = 1'b0;
        beat(-3, 2); beat(-3, 2); beat(-3, 2);
        fork
            beat(-1, 2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stall", bus.in_ready_o, 0);
                    chk("bp_hold", bus.out_data_o, 25);
                end
                @(posedge clk);
                #1;
                bus.out_ready_i = 1'b1;
            end
        join
        chk("bp_valid", bus.out_valid_o, 1);
        chk("bp_second", bus.out_data_o, -2);
        @(posedge clk);
        #1;

        // Shift is taken from the first beat only.
        beat(1, 1); beat(1, 7); beat(1, 7); beat(2, 7);
        chk("shift_sample", bus.out_data_o, 3);
        @(posedge clk);
        #1;

        // Asynchronous reset with a pending result and a partial group.
        bus.out_ready_i = 1'b0;
        group4(1, 1, 1, 1, 0);
        beat(1, 0); beat(1, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid_o, 0);
        chk("arst_out_data", bus.out_data_o, 0);
        chk("arst_out_sat", bus.out_sat_o, 0);
        chk("arst_in_ready", bus.in_ready_o, 1);
        mcnt = 0;
        expq.delete();
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        group4(1, 1, 1, 1, 0);
        chk("post_rst_data", bus.out_data_o, 4);
        chk("post_rst_valid", bus.out_valid_o, 1);

        // Random groups, random idle gaps and random consumer stalls.
        fork
            begin
                for (int g = 0; g < 300; g++) begin
                    for (int b = 0; b < NA; b++) begin
                        logic signed [IW-1:0] rv;
                        longint d;
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if ($urandom_range(0, 1) == 1) begin
                            rv = IW'($urandom);
                            d  = rv;
                        end else begin
                            d = longint'($urandom_range(0, 4000)) - 2000;
                        end
                        beat(d, int'($urandom_range(0, 31)));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready_i = ($urandom_range(0, 1) == 1);
                end
            end
        join

        bus.out_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", expq.size(), 0);
        chk("drain_valid", bus.out_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_requant.md
# psum_requant

Downstream stage of the signed adder tree. Accepts one adder-tree sum per beat over a valid/ready handshake and accumulates a fixed group of `NumAcc` consecutive sums. At the end of each group it applies a round-half-up arithmetic right shift and signed saturation to `OutWidth` bits. The result is held in an output register with its own valid/ready handshake.

## Interface
- `InWidth`, default 20: signed width of the incoming adder-tree sum.
- `NumAcc`, default 4: beats per accumulation group; must be ≥ 1.
- `OutWidth`, default 8: signed output width.
- `ShiftWidth`, default 5: width of the shift-amount input.
- `AccWidth` (localparam) = `InWidth + $clog2(NumAcc)`: accumulator width. This width cannot overflow.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `in_valid_i`, in, 1: input sum is valid.
- `in_ready_o`, out, 1: block accepts the input sum.
- `in_data_i`, in, `InWidth`, signed: sum from the adder tree.
- `shift_i`, in, `ShiftWidth`: right-shift amount. Sampled only on the first beat of a group.
- `out_valid_o`, out, 1: result register holds a valid result.
- `out_ready_i`, in, 1: consumer takes the result.
- `out_data_o`, out, `OutWidth`, signed: requantized result.
- `out_sat_o`, out, 1: the result in `out_data_o` was clipped.

## Operation
- A beat is accepted when `in_valid_i && in_ready_o`.
- `cnt` is the beat counter, 0..`NumAcc-1`. It wraps to 0 after the last beat of a group.
- `in_ready_o` is 0 only when both of these hold:
  - `cnt == NumAcc-1`;
  - `out_valid_o && !out_ready_i`.
- Consequence: beats 0..`NumAcc-2` are accepted while a result is still waiting. Only the last beat of a group stalls.
- First beat (`cnt == 0`):
  - `acc` is loaded with the sign-extended `in_data_i`; the previous contents are discarded.
  - `shift_q` is loaded with `shift_i`.
- Middle beats: `acc += in_data_i`.
- Last beat (`cnt == NumAcc-1`):
  - `total = acc + in_data_i`. If `NumAcc == 1`, `total = in_data_i` and `shift_i` is used directly.
  - `s = min(shift, AccWidth-1)`.
  - `r = (total + (s > 0 ? 2^(s-1) : 0)) >>> s`. The addition is done at `AccWidth+1` bits, so there is no intermediate overflow.
  - If `r > 2^(OutWidth-1)-1`, the output is the maximum positive value and `out_sat_o` = 1.
  - If `r < -2^(OutWidth-1)`, the output is the minimum negative value and `out_sat_o` = 1.
  - Otherwise the output is `r` truncated to `OutWidth` and `out_sat_o` = 0.
  - The result is registered into `out_data_o`/`out_sat_o`, and `out_valid_o` is set.
- Output register:
  - `out_valid_o` clears on `out_ready_i` unless a new last beat is accepted in the same cycle. In that case the new result replaces the old one and `out_valid_o` stays 1.
  - `out_data_o` and `out_sat_o` are stable while `out_valid_o && !out_ready_i`.
- `shift_i` changes during a group are ignored.

## Timing
- Reset values (asynchronous, apply immediately):
  - `cnt`, `acc`, `shift_q` = 0;
  - `out_valid_o` = 0, `out_data_o` = 0, `out_sat_o` = 0;
  - `in_ready_o` = 1.
- Reset mid-group discards the partial accumulation and any pending result. The next accepted beat is beat 0.
- Latency: last beat accepted at edge t, so `out_valid_o` = 1 after edge t.
- Throughput: one result per `NumAcc` cycles with no bubbles when `out_ready_i` is held at 1.
- `in_ready_o` is combinational from `cnt`, `out_valid_o` and `out_ready_i`. There is no combinational path from `in_valid_i` to `in_ready_o`.
- The outputs `out_data_o`, `out_sat_o` and `out_valid_o` are registered.
- `in_valid_i` low: no state changes except output drain.

## Test plan
- Group of 10, 20, 30, 40 with `shift_i` = 2 and `out_ready_i` = 1 → `out_data_o` = 25, `out_sat_o` = 0. `out_valid_o` is high for 1 cycle, the cycle after the 4th beat.
- Group of −3, −3, −3, −1 with shift 2 → −2 (round half up of −2.5), `out_sat_o` = 0.
- Saturation:
  - group of 4×100000 with shift 0 → 127, `out_sat_o` = 1;
  - group of 4×(−100000) with shift 0 → −128, `out_sat_o` = 1.
- Backpressure: hold `out_ready_i` = 0 after the first result.
  - The next group's beats 0–2 are accepted.
  - Beat 3 sees `in_ready_o` = 0 until `out_ready_i` rises.
  - In that cycle beat 3 is accepted, and the second result follows with no loss or duplication.
- Shift sampling: first beat with shift 1, then shift changed to 7 for beats 1–3 on group 1, 1, 1, 2 → output 3 (5 rounded up after shift 1).
- Reset mid-group: accept 2 beats, pulse `rst_i` asynchronously → all outputs are 0 immediately. Then group 1, 1, 1, 1 with shift 0 → 4.
